// File: rtl/mips_fetch_pkg.sv
// Shared fetch-stage definitions: state encoding, PC increment and default reset PC.
package mips_fetch_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 16;

   localparam logic [XLEN-1:0] PC_INC           = 32'd4;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_VALID = 2'd2,
      ST_FLUSH = 2'd3
   } fetch_state_e;

   // Force a byte address onto a word boundary.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & ~(32'd3);
   endfunction

endpackage

// File: rtl/pc_fetch.sv
// Instruction fetch stage: PC register, single-outstanding imem request and redirect squashing.
// Optional redirect counter enabled by defining REDIRECT_CNT_EN.
module pc_fetch
   import mips_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic              imem_req,
   output logic [XLEN-1:0]   imem_addr,
   input  logic              imem_ack,
   input  logic [XLEN-1:0]   imem_rdata,
   output logic              if_valid,
   output logic [XLEN-1:0]   if_instr,
   output logic [XLEN-1:0]   if_pc,
   input  logic              if_ready,
   output logic [XLEN-1:0]   pc_plus4,
   output logic [CNT_W-1:0]  redirect_count
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            req_q, req_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic            vld_q, vld_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] ifpc_q, ifpc_d;
   logic [XLEN-1:0] redir_tgt;

   assign redir_tgt = word_align(redirect_pc);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         req_q   <= 1'b0;
         addr_q  <= RESET_PC;
         vld_q   <= 1'b0;
         instr_q <= '0;
         ifpc_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         vld_q   <= vld_d;
         instr_q <= instr_d;
         ifpc_q  <= ifpc_d;
      end
   end

   // Redirect always wins; an in-flight request is never aborted, only its data dropped.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      req_d   = req_q;
      addr_d  = addr_q;
      vld_d   = vld_q;
      instr_d = instr_q;
      ifpc_d  = ifpc_q;

      case (state_q)
         ST_IDLE: begin
            state_d = ST_REQ;
            req_d   = 1'b1;
            if (redirect_valid) begin
               pc_d   = redir_tgt;
               addr_d = redir_tgt;
            end else begin
               addr_d = pc_q;
            end
         end

         ST_REQ: begin
            if (redirect_valid) begin
               pc_d = redir_tgt;
               if (imem_ack) begin
                  addr_d  = redir_tgt;
                  state_d = ST_REQ;
               end else begin
                  state_d = ST_FLUSH;
               end
            end else if (imem_ack) begin
               instr_d = imem_rdata;
               ifpc_d  = addr_q;
               vld_d   = 1'b1;
               pc_d    = pc_q + PC_INC;
               req_d   = 1'b0;
               state_d = ST_VALID;
            end
         end

         ST_VALID: begin
            if (redirect_valid) begin
               vld_d   = 1'b0;
               pc_d    = redir_tgt;
               addr_d  = redir_tgt;
               req_d   = 1'b1;
               state_d = ST_REQ;
            end else if (if_ready) begin
               vld_d   = 1'b0;
               addr_d  = pc_q;
               req_d   = 1'b1;
               state_d = ST_REQ;
            end
         end

         ST_FLUSH: begin
            if (redirect_valid) begin
               pc_d = redir_tgt;
               if (imem_ack) begin
                  addr_d  = redir_tgt;
                  state_d = ST_REQ;
               end
            end else if (imem_ack) begin
               addr_d  = pc_q;
               state_d = ST_REQ;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign imem_req  = req_q;
   assign imem_addr = addr_q;
   assign if_valid  = vld_q;
   assign if_instr  = instr_q;
   assign if_pc     = ifpc_q;
   assign pc_plus4  = pc_q + PC_INC;

`ifdef REDIRECT_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturating count of redirect cycles.
   always_comb begin
      cnt_d = cnt_q;
      if (redirect_valid && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign redirect_count = cnt_q;
`else
   assign redirect_count = '0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: vector table of sequential fetches plus redirect/reset corner sequences.
module tb_pc_fetch;
   import mips_fetch_pkg::*;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] rdata;
      int          ack_dly;
      int          rdy_dly;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   n_redir = 0;

   logic        clk = 1'b0;
   logic        rst, redirect_valid, imem_ack, if_ready;
   logic [31:0] redirect_pc, imem_rdata;
   logic        imem_req, if_valid;
   logic [31:0] imem_addr, if_instr, if_pc, pc_plus4;
   logic [15:0] redirect_count;

   logic        rst1, redirect_valid1, imem_ack1, if_ready1;
   logic [31:0] redirect_pc1, imem_rdata1;
   logic        imem_req1, if_valid1;
   logic [31:0] imem_addr1, if_instr1, if_pc1, pc_plus4_1;
   logic [15:0] redirect_count1;

   always #5 clk = ~clk;

   pc_fetch u_dut (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .if_ready(if_ready), .pc_plus4(pc_plus4), .redirect_count(redirect_count)
   );

   pc_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_hi (
      .clk(clk), .rst(rst1),
      .redirect_valid(redirect_valid1), .redirect_pc(redirect_pc1),
      .imem_req(imem_req1), .imem_addr(imem_addr1),
      .imem_ack(imem_ack1), .imem_rdata(imem_rdata1),
      .if_valid(if_valid1), .if_instr(if_instr1), .if_pc(if_pc1),
      .if_ready(if_ready1), .pc_plus4(pc_plus4_1), .redirect_count(redirect_count1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   function automatic logic [15:0] exp_cnt(input int n);
`ifdef REDIRECT_CNT_EN
      return (n >= 65535) ? 16'hFFFF : 16'(n);
`else
      return (n < 0) ? 16'hFFFF : 16'h0000;
`endif
   endfunction

   task automatic tick();
      if (redirect_valid) n_redir++;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req();
      int n = 0;
      while (!imem_req && n < 10) begin
         tick();
         n++;
      end
      chk1("req_timeout", imem_req, 1'b1);
   endtask

   // One complete fetch through the scoreboard: request, ack, optional decode stall, handshake.
   task automatic fetch_one(input vec_t v);
      exp_t e;
      wait_req();
      chk("imem_addr", imem_addr, v.addr);
      chk("pc_plus4", pc_plus4, v.addr + 32'd4);
      for (int i = 0; i < v.ack_dly; i++) begin
         tick();
         chk1("req_hold", imem_req, 1'b1);
         chk("addr_hold", imem_addr, v.addr);
      end
      imem_ack   = 1'b1;
      imem_rdata = v.rdata;
      e.pc       = v.addr;
      e.instr    = v.rdata;
      sb.push_back(e);
      tick();
      imem_ack   = 1'b0;
      imem_rdata = '0;
      chk1("if_valid", if_valid, 1'b1);
      for (int i = 0; i < v.rdy_dly; i++) begin
         if_ready = 1'b0;
         tick();
         chk1("hold_valid", if_valid, 1'b1);
         chk("hold_instr", if_instr, sb[0].instr);
         chk("hold_pc", if_pc, sb[0].pc);
         chk1("no_req", imem_req, 1'b0);
      end
      if_ready = 1'b1;
      chk("sb_size", 32'(sb.size()), 32'd1);
      e = sb.pop_front();
      chk("if_pc", if_pc, e.pc);
      chk("if_instr", if_instr, e.instr);
      tick();
      if_ready = 1'b0;
      chk1("if_valid_clr", if_valid, 1'b0);
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[5];
      int   n_burst;
      vt[0] = '{addr: 32'h0000_0000, rdata: 32'h1111_0000, ack_dly: 0, rdy_dly: 0};
      vt[1] = '{addr: 32'h0000_0004, rdata: 32'h1111_0004, ack_dly: 0, rdy_dly: 0};
      vt[2] = '{addr: 32'h0000_0008, rdata: 32'h1111_0008, ack_dly: 0, rdy_dly: 0};
      vt[3] = '{addr: 32'h0000_000C, rdata: 32'hCAFE_000C, ack_dly: 0, rdy_dly: 5};
      vt[4] = '{addr: 32'h0000_0010, rdata: 32'h5A5A_0010, ack_dly: 3, rdy_dly: 1};

      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
      imem_ack = 1'b0; imem_rdata = '0; if_ready = 1'b0;
      rst1 = 1'b1; redirect_valid1 = 1'b0; redirect_pc1 = '0;
      imem_ack1 = 1'b0; imem_rdata1 = '0; if_ready1 = 1'b0;
      tick();
      tick();

      chk1("rst_req", imem_req, 1'b0);
      chk("rst_addr", imem_addr, 32'h0000_0000);
      chk1("rst_valid", if_valid, 1'b0);
      chk("rst_instr", if_instr, 32'h0);
      chk("rst_if_pc", if_pc, 32'h0);
      chk("rst_plus4", pc_plus4, 32'h0000_0004);
      chk("rst_cnt", 32'(redirect_count), 32'h0);

      rst = 1'b0;
      tick();

      for (int i = 0; i < 5; i++) fetch_one(vt[i]);

      // Redirect while request outstanding, ack arrives later and is dropped.
      wait_req();
      chk("a_addr", imem_addr, 32'h0000_0014);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      tick();
      redirect_valid = 1'b0;
      chk1("a_req", imem_req, 1'b1);
      chk("a_addr_keep", imem_addr, 32'h0000_0014);
      chk("a_plus4", pc_plus4, 32'h0000_0104);
      tick();
      tick();
      chk1("a_req_flush", imem_req, 1'b1);
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_ack   = 1'b0;
      chk1("a_valid", if_valid, 1'b0);
      chk("a_new_addr", imem_addr, 32'h0000_0100);
      chk1("a_req2", imem_req, 1'b1);
      fetch_one('{addr: 32'h0000_0100, rdata: 32'h2222_0100, ack_dly: 0, rdy_dly: 0});

      // Redirect coincident with ack.
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      imem_ack       = 1'b1;
      imem_rdata     = 32'hBAD0_0001;
      tick();
      redirect_valid = 1'b0;
      imem_ack       = 1'b0;
      chk1("b_valid", if_valid, 1'b0);
      chk("b_addr", imem_addr, 32'h0000_0200);
      chk1("b_req", imem_req, 1'b1);
      tick();
      chk1("b_valid2", if_valid, 1'b0);

      // Two redirects during flush: last one wins.
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0302;
      tick();
      chk("c_addr_keep", imem_addr, 32'h0000_0200);
      redirect_pc    = 32'h0000_0400;
      tick();
      redirect_valid = 1'b0;
      chk1("c_valid", if_valid, 1'b0);
      imem_ack   = 1'b1;
      imem_rdata = 32'hBAD0_0002;
      tick();
      imem_ack   = 1'b0;
      chk("c_addr", imem_addr, 32'h0000_0400);
      chk1("c_valid2", if_valid, 1'b0);

      // Redirect in VALID squashes even with if_ready high.
      imem_ack   = 1'b1;
      imem_rdata = 32'h3333_0400;
      tick();
      imem_ack   = 1'b0;
      chk1("d_valid", if_valid, 1'b1);
      chk("d_instr", if_instr, 32'h3333_0400);
      if_ready       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0500;
      tick();
      if_ready       = 1'b0;
      redirect_valid = 1'b0;
      chk1("d_squash", if_valid, 1'b0);
      chk("d_addr", imem_addr, 32'h0000_0500);
      chk1("d_req", imem_req, 1'b1);
      fetch_one('{addr: 32'h0000_0500, rdata: 32'h4444_0500, ack_dly: 1, rdy_dly: 2});
      chk("cnt_small", 32'(redirect_count), 32'(exp_cnt(n_redir)));

      // Long redirect burst exercises counter saturation.
`ifdef REDIRECT_CNT_EN
      n_burst = 70000;
`else
      n_burst = 40;
`endif
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0600;
      for (int i = 0; i < n_burst; i++) tick();
      redirect_valid = 1'b0;
      chk("cnt_burst", 32'(redirect_count), 32'(exp_cnt(n_redir)));

      // High reset PC wraps to zero; async reset drops the request at once.
      rst1 = 1'b0;
      tick();
      chk1("h_req", imem_req1, 1'b1);
      chk("h_addr", imem_addr1, 32'hFFFF_FFFC);
      chk("h_plus4", pc_plus4_1, 32'h0000_0000);
      imem_ack1   = 1'b1;
      imem_rdata1 = 32'h7777_FFFC;
      tick();
      imem_ack1   = 1'b0;
      chk1("h_valid", if_valid1, 1'b1);
      chk("h_if_pc", if_pc1, 32'hFFFF_FFFC);
      if_ready1 = 1'b1;
      tick();
      if_ready1 = 1'b0;
      chk("h_addr2", imem_addr1, 32'h0000_0000);
      chk1("h_req2", imem_req1, 1'b1);
      rst1 = 1'b1;
      #1;
      chk1("h_rst_req", imem_req1, 1'b0);
      chk("h_rst_addr", imem_addr1, 32'hFFFF_FFFC);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
